// File: rtl/riscat_pkg.sv
// riscat_pkg: shared definitions for the RISCAT integer register file.
//   REG_COUNT      number of architectural integer registers
//   REG_ADDR_BITS  width of a register index
//   reg_addr_t     register index type
//   busy_vec_t     one pending-write flag per register
//   popcount       number of set flags in a busy_vec_t
package riscat_pkg;

  localparam int REG_COUNT     = 32;
  localparam int REG_ADDR_BITS = 5;

  typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;
  typedef logic [REG_COUNT-1:0]     busy_vec_t;

  // Result fits in 6 bits: at most 31 flags can be set because x0 never is.
  function automatic logic [5:0] popcount(input busy_vec_t v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      c = c + {5'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write bitmap for the integer register file.
//   clk, reset          rising-edge clock, synchronous active-high reset
//   issue_en, issue_rd  mark issue_rd busy (a producer was issued)
//   wr_en, wr_addr      clear wr_addr (its producer wrote back)
//   busy                registered bitmap; bit 0 is always 0
//   busy_count          registered population count of busy
// When the same register is issued and written back on one edge, the set
// wins: the newly issued producer supersedes the completing one.
module reg_scoreboard
  import riscat_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_en,
  input  logic [4:0]  issue_rd,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  output logic [31:0] busy,
  output logic [5:0]  busy_count
);

  busy_vec_t busy_q;
  busy_vec_t busy_next;

  always_comb begin
    busy_next = busy_q;
    if (wr_en && (wr_addr != '0)) begin
      busy_next[wr_addr] = 1'b0;
    end
    // Applied after the clear so that a same-edge issue keeps the bit set.
    if (issue_en && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Count is computed from the next state so it always matches busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= '0;
      busy_count <= '0;
    end else begin
      busy_q     <= busy_next;
      busy_count <= popcount(busy_next);
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/register_file.sv
// register_file: 32 x DATA_BITS integer register file with pending-write
// scoreboard, between issue and execute.
//   clk, reset               rising-edge clock, synchronous active-high reset
//   rd_addr0/1               read indices (combinational reads)
//   rd_data0/1, rd_busy0/1   read value and pending-write flag
//   wr_en, wr_addr, wr_data  writeback port (writes to x0 are dropped)
//   issue_en, issue_rd       destination of an instruction issued this cycle
//   busy_count               number of registers with a pending write
// Build option REGISTER_FILE_BYPASS_EN: forward a same-cycle writeback to a
// matching read port and hide its busy flag (zero-cycle writeback-to-read).
module register_file
  import riscat_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rd_addr0,
  input  logic [4:0]           rd_addr1,
  output logic [DATA_BITS-1:0] rd_data0,
  output logic [DATA_BITS-1:0] rd_data1,
  output logic                 rd_busy0,
  output logic                 rd_busy1,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 issue_en,
  input  logic [4:0]           issue_rd,
  output logic [5:0]           busy_count
);

  // x0 is not stored; entries 1..31 only.
  logic [DATA_BITS-1:0] regs [1:REG_COUNT-1];
  logic [31:0]          busy;
  logic [DATA_BITS-1:0] raw0;
  logic [DATA_BITS-1:0] raw1;
  logic                 wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  // Write steering: only the addressed entry loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .busy_count (busy_count)
  );

  // 32:1 read selectors; index 0 reads as zero.
  always_comb begin
    raw0 = '0;
    raw1 = '0;
    if (rd_addr0 != '0) raw0 = regs[rd_addr0];
    if (rd_addr1 != '0) raw1 = regs[rd_addr1];
  end

`ifdef REGISTER_FILE_BYPASS_EN
  logic hit0;
  logic hit1;

  assign hit0     = wr_live && (rd_addr0 == wr_addr);
  assign hit1     = wr_live && (rd_addr1 == wr_addr);
  assign rd_data0 = hit0 ? wr_data : raw0;
  assign rd_data1 = hit1 ? wr_data : raw1;
  // The value being forwarded is the one the reader was waiting for.
  assign rd_busy0 = busy[rd_addr0] & ~hit0;
  assign rd_busy1 = busy[rd_addr1] & ~hit1;
`else
  assign rd_data0 = raw0;
  assign rd_data1 = raw1;
  assign rd_busy0 = busy[rd_addr0];
  assign rd_busy1 = busy[rd_addr1];
`endif

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_addr0, rd_addr1;
  logic [31:0] rd_data0, rd_data1;
  logic        rd_busy0, rd_busy1;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [5:0]  busy_count;

  int passed = 0;
  int total  = 0;

  // Reference state: plain arrays, updated from the architectural rules.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  register_file #(.DATA_BITS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr0   (rd_addr0),
    .rd_addr1   (rd_addr1),
    .rd_data0   (rd_data0),
    .rd_data1   (rd_data1),
    .rd_busy0   (rd_busy0),
    .rd_busy1   (rd_busy1),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .busy_count (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        eb0;
    logic        eb1;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGISTER_FILE_BYPASS_EN
    if (wr_en && wr_addr != 5'd0 && a == wr_addr) return wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef REGISTER_FILE_BYPASS_EN
    if (wr_en && wr_addr != 5'd0 && a == wr_addr) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic logic [5:0] exp_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return 6'(n);
  endfunction

  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_rd = '0;
  endtask

  // Compare all outputs against the reference model at the falling edge.
  task automatic check_model(input string tag);
    @(negedge clk);
    chk({tag, " rd_data0"}, rd_data0, exp_data(rd_addr0));
    chk({tag, " rd_data1"}, rd_data1, exp_data(rd_addr1));
    chk({tag, " rd_busy0"}, {31'b0, rd_busy0}, {31'b0, exp_busy(rd_addr0)});
    chk({tag, " rd_busy1"}, {31'b0, rd_busy1}, {31'b0, exp_busy(rd_addr1)});
    chk({tag, " busy_count"}, {26'b0, busy_count}, {26'b0, exp_count()});
  endtask

  // Advance one edge and apply the same edge to the reference model.
  task automatic edge_update();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 5'd0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (issue_en && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = 5'(i);
      rd_addr1 = 5'(31 - i);
      @(negedge clk);
      chk({tag, " data0"}, rd_data0, 32'h0);
      chk({tag, " data1"}, rd_data1, 32'h0);
      chk({tag, " busy0"}, {31'b0, rd_busy0}, 32'h0);
      chk({tag, " busy1"}, {31'b0, rd_busy1}, 32'h0);
      chk({tag, " count"}, {26'b0, busy_count}, 32'h0);
      edge_update();
    end
  endtask

  initial begin
    // wr_en wr_addr wr_data issue_en issue_rd ra0 ra1 ed0 ed1 eb0 eb1 ecnt
    vecs[0]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd0, 32'h0,        32'h0,        0, 0, 6'd0};
    vecs[1]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd1, 5'd2, 32'h0,        32'h0,        0, 0, 6'd0};
    vecs[2]  = '{1, 5'd0, 32'h12345678, 0, 5'd0, 5'd1, 5'd2, 32'h0,        32'h0,        0, 0, 6'd0};
    vecs[3]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        0, 0, 6'd0};
    vecs[4]  = '{0, 5'd0, 32'h0,        1, 5'd7, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 0, 0, 6'd0};
    vecs[5]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 1, 0, 6'd1};
    vecs[6]  = '{1, 5'd7, 32'hA5A5A5A5, 0, 5'd0, 5'd5, 5'd6, 32'hDEADBEEF, 32'h0,        0, 0, 6'd1};
    vecs[7]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 6'd0};
    vecs[8]  = '{1, 5'd9, 32'h00000011, 1, 5'd9, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        0, 0, 6'd0};
    vecs[9]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd9, 32'h00000011, 32'h00000011, 1, 1, 6'd1};
    vecs[10] = '{0, 5'd0, 32'h0,        1, 5'd9, 5'd9, 5'd0, 32'h00000011, 32'h0,        1, 0, 6'd1};
    vecs[11] = '{1, 5'd5, 32'h00000055, 0, 5'd0, 5'd9, 5'd1, 32'h00000011, 32'h0,        1, 0, 6'd1};
    vecs[12] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd9, 32'h00000055, 32'h00000011, 0, 1, 6'd1};

    idle();
    rd_addr0 = '0; rd_addr1 = '0;
    reset = 1'b1;
    #1;
    edge_update();
    edge_update();
    reset = 1'b0;

    // After reset every index reads zero and nothing is busy.
    sweep_zero("reset_sweep");

    // Directed table.
    for (int v = 0; v < 13; v++) begin
      wr_en = vecs[v].wr_en; wr_addr = vecs[v].wr_addr; wr_data = vecs[v].wr_data;
      issue_en = vecs[v].issue_en; issue_rd = vecs[v].issue_rd;
      rd_addr0 = vecs[v].ra0; rd_addr1 = vecs[v].ra1;
      @(negedge clk);
      chk($sformatf("vec%0d rd_data0", v), rd_data0, vecs[v].ed0);
      chk($sformatf("vec%0d rd_data1", v), rd_data1, vecs[v].ed1);
      chk($sformatf("vec%0d rd_busy0", v), {31'b0, rd_busy0}, {31'b0, vecs[v].eb0});
      chk($sformatf("vec%0d rd_busy1", v), {31'b0, rd_busy1}, {31'b0, vecs[v].eb1});
      chk($sformatf("vec%0d busy_count", v), {26'b0, busy_count}, {26'b0, vecs[v].ecnt});
      edge_update();
    end
    idle();

    // Same-cycle writeback to a busy register being read.
    issue_en = 1'b1; issue_rd = 5'd3; rd_addr0 = 5'd3; rd_addr1 = 5'd0;
    check_model("issue_x3");
    edge_update();
    idle();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEF00D;
    @(negedge clk);
`ifdef REGISTER_FILE_BYPASS_EN
    chk("bypass_x3 data", rd_data0, 32'hCAFEF00D);
    chk("bypass_x3 busy", {31'b0, rd_busy0}, 32'h0);
`else
    chk("nobypass_x3 data", rd_data0, 32'h0);
    chk("nobypass_x3 busy", {31'b0, rd_busy0}, 32'h1);
`endif
    edge_update();
    idle();
    @(negedge clk);
    chk("after_x3 data", rd_data0, 32'hCAFEF00D);
    chk("after_x3 busy", {31'b0, rd_busy0}, 32'h0);
    edge_update();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 63) == 0);
      wr_en    = $urandom_range(0, 1);
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      issue_en = $urandom_range(0, 1);
      issue_rd = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr1 = ($urandom_range(0, 3) == 0) ? issue_rd : 5'($urandom_range(0, 31));
      check_model($sformatf("rand%0d", n));
      edge_update();
    end
    idle();

    // Fill the scoreboard, then reset with a concurrent write and issue.
    reset = 1'b1;
    edge_update();
    idle();
    for (int i = 1; i < 32; i++) begin
      issue_en = 1'b1; issue_rd = 5'(i); rd_addr0 = 5'(i); rd_addr1 = 5'(i - 1);
      check_model($sformatf("fill%0d", i));
      edge_update();
    end
    idle();
    rd_addr0 = 5'd31; rd_addr1 = 5'd4;
    @(negedge clk);
    chk("full busy_count", {26'b0, busy_count}, 32'd31);
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFFFFFFFF;
    issue_en = 1'b1; issue_rd = 5'd4;
    edge_update();
    idle();
    sweep_zero("reset_override");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
